// File: rtl/mem_port_arbiter.sv
// Arbitrates the single unified memory port between instruction fetch (IF) and load/store (LS).
// LS has priority. An IF grant is forced after MAX_WAIT consecutive losses while IF is waiting.
//
// state   | meaning
// IDLE    | no transaction outstanding; arbitrates on any request
// BUSY_IF | fetch transaction outstanding, waiting for mem_ack_i
// BUSY_LS | load/store transaction outstanding, waiting for mem_ack_i
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  input  logic                ls_req_i,
  input  logic                ls_we_i,
  input  logic [ADDR_W-1:0]   ls_addr_i,
  input  logic [DATA_W-1:0]   ls_wdata_i,
  input  logic [DATA_W/8-1:0] ls_wstrb_i,
  output logic                ls_gnt_o,
  output logic                ls_rvalid_o,
  output logic [DATA_W-1:0]   ls_rdata_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_wstrb_o,
  input  logic                mem_ack_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic                busy_o
);

  localparam int STRB_W = DATA_W / 8;
  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_LS} state_t;

  state_t              state_q, state_d;
  logic [3:0]          starve_q, starve_d;
  logic                if_win, ls_win;

  logic                if_gnt_q, if_gnt_d;
  logic                if_rvalid_q, if_rvalid_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic                ls_gnt_q, ls_gnt_d;
  logic                ls_rvalid_q, ls_rvalid_d;
  logic [DATA_W-1:0]   ls_rdata_q, ls_rdata_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [STRB_W-1:0]   mem_wstrb_q, mem_wstrb_d;

  // Winner selection; only meaningful in IDLE.
  always_comb begin
    if_win = 1'b0;
    ls_win = 1'b0;
    if (state_q == IDLE) begin
      if (if_req_i && (starve_q == MAX_WAIT_C)) if_win = 1'b1;
      else if (ls_req_i)                        ls_win = 1'b1;
      else if (if_req_i)                        if_win = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      if_gnt_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      ls_gnt_q    <= 1'b0;
      ls_rvalid_q <= 1'b0;
      ls_rdata_q  <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      if_gnt_q    <= if_gnt_d;
      if_rvalid_q <= if_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      ls_gnt_q    <= ls_gnt_d;
      ls_rvalid_q <= ls_rvalid_d;
      ls_rdata_q  <= ls_rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (if_win)      state_d = BUSY_IF;
        else if (ls_win) state_d = BUSY_LS;
      end
      BUSY_IF, BUSY_LS: begin
        if (mem_ack_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    starve_d    = starve_q;
    if_gnt_d    = 1'b0;
    if_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    ls_gnt_d    = 1'b0;
    ls_rvalid_d = 1'b0;
    ls_rdata_d  = ls_rdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    case (state_q)
      IDLE: begin
        if (if_win) begin
          if_gnt_d    = 1'b1;
          starve_d    = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr_i;
          mem_wdata_d = '0;
          mem_wstrb_d = '0;
        end else if (ls_win) begin
          ls_gnt_d    = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = ls_we_i;
          mem_addr_d  = ls_addr_i;
          mem_wdata_d = ls_wdata_i;
          mem_wstrb_d = ls_we_i ? ls_wstrb_i : '0;
          // Only a loss while IF is actually waiting counts toward starvation.
          if (if_req_i && (starve_q != MAX_WAIT_C)) starve_d = starve_q + 4'd1;
        end
      end
      BUSY_IF: begin
        if (mem_ack_i) begin
          mem_req_d   = 1'b0;
          if_rvalid_d = 1'b1;
          if_rdata_d  = mem_rdata_i;
        end
      end
      BUSY_LS: begin
        if (mem_ack_i) begin
          mem_req_d   = 1'b0;
          ls_rvalid_d = 1'b1;
          ls_rdata_d  = mem_rdata_i;
        end
      end
      default: ;
    endcase
  end

  assign if_gnt_o    = if_gnt_q;
  assign if_rvalid_o = if_rvalid_q;
  assign if_rdata_o  = if_rdata_q;
  assign ls_gnt_o    = ls_gnt_q;
  assign ls_rvalid_o = ls_rvalid_q;
  assign ls_rdata_o  = ls_rdata_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_wstrb_o = mem_wstrb_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: hand-computed expectations checked with immediate assertions.
module tb_mem_port_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic        if_gnt_o, if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        ls_req_i = 1'b0;
  logic        ls_we_i = 1'b0;
  logic [31:0] ls_addr_i = '0;
  logic [31:0] ls_wdata_i = '0;
  logic [3:0]  ls_wstrb_i = '0;
  logic        ls_gnt_o, ls_rvalid_o;
  logic [31:0] ls_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_wstrb_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        busy_o;

  int vectors = 0;
  int errors  = 0;

  always #5 clk_i = ~clk_i;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i),
    .if_gnt_o(if_gnt_o), .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_addr_i(ls_addr_i),
    .ls_wdata_i(ls_wdata_i), .ls_wstrb_i(ls_wstrb_i),
    .ls_gnt_o(ls_gnt_o), .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i), .busy_o(busy_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, "_if_gnt"}, if_gnt_o, 1'b0);
    chk1({tag, "_if_rvalid"}, if_rvalid_o, 1'b0);
    chk32({tag, "_if_rdata"}, if_rdata_o, 32'h0);
    chk1({tag, "_ls_gnt"}, ls_gnt_o, 1'b0);
    chk1({tag, "_ls_rvalid"}, ls_rvalid_o, 1'b0);
    chk32({tag, "_ls_rdata"}, ls_rdata_o, 32'h0);
    chk1({tag, "_mem_req"}, mem_req_o, 1'b0);
    chk1({tag, "_mem_we"}, mem_we_o, 1'b0);
    chk32({tag, "_mem_addr"}, mem_addr_o, 32'h0);
    chk32({tag, "_mem_wdata"}, mem_wdata_o, 32'h0);
    chk32({tag, "_mem_wstrb"}, {28'h0, mem_wstrb_o}, 32'h0);
    chk1({tag, "_busy"}, busy_o, 1'b0);
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk_all_zero("reset");
    rst_i = 1'b0;
    tick();

    // 1. IF fetch with two wait cycles
    if_req_i = 1'b1; if_addr_i = 32'h100;
    tick();
    chk1("t1_if_gnt", if_gnt_o, 1'b1);
    chk1("t1_ls_gnt", ls_gnt_o, 1'b0);
    chk1("t1_mem_req_c1", mem_req_o, 1'b1);
    chk32("t1_mem_addr_c1", mem_addr_o, 32'h100);
    chk1("t1_mem_we_c1", mem_we_o, 1'b0);
    chk1("t1_busy", busy_o, 1'b1);
    if_req_i = 1'b0;
    tick();
    chk1("t1_if_gnt_once", if_gnt_o, 1'b0);
    chk1("t1_mem_req_c2", mem_req_o, 1'b1);
    chk32("t1_mem_addr_c2", mem_addr_o, 32'h100);
    tick();
    chk1("t1_mem_req_c3", mem_req_o, 1'b1);
    chk32("t1_mem_addr_c3", mem_addr_o, 32'h100);
    chk1("t1_mem_we_c3", mem_we_o, 1'b0);
    chk1("t1_no_early_rvalid", if_rvalid_o, 1'b0);
    mem_ack_i = 1'b1; mem_rdata_i = 32'h00500093;
    tick();
    chk1("t1_if_rvalid", if_rvalid_o, 1'b1);
    chk32("t1_if_rdata", if_rdata_o, 32'h00500093);
    chk1("t1_mem_req_drop", mem_req_o, 1'b0);
    chk1("t1_busy_drop", busy_o, 1'b0);
    mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    tick();
    chk1("t1_rvalid_pulse", if_rvalid_o, 1'b0);
    chk32("t1_rdata_hold", if_rdata_o, 32'h00500093);

    // 2. Simultaneous requests: LS store wins, IF follows
    if_req_i = 1'b1; if_addr_i = 32'h104;
    ls_req_i = 1'b1; ls_we_i = 1'b1; ls_addr_i = 32'h2000;
    ls_wdata_i = 32'hDEADBEEF; ls_wstrb_i = 4'hF;
    tick();
    chk1("t2_ls_gnt", ls_gnt_o, 1'b1);
    chk1("t2_if_gnt_lost", if_gnt_o, 1'b0);
    chk1("t2_mem_we", mem_we_o, 1'b1);
    chk32("t2_mem_addr", mem_addr_o, 32'h2000);
    chk32("t2_mem_wdata", mem_wdata_o, 32'hDEADBEEF);
    chk32("t2_mem_wstrb", {28'h0, mem_wstrb_o}, 32'hF);
    ls_req_i = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'h5A5A5A5A;
    tick();
    chk1("t2_ls_rvalid", ls_rvalid_o, 1'b1);
    chk1("t2_no_b2b_gnt", if_gnt_o, 1'b0);
    chk1("t2_busy_idle", busy_o, 1'b0);
    mem_ack_i = 1'b0;
    tick();
    chk1("t2_if_gnt", if_gnt_o, 1'b1);
    chk32("t2_if_addr", mem_addr_o, 32'h104);
    chk1("t2_if_we", mem_we_o, 1'b0);
    chk32("t2_if_wstrb", {28'h0, mem_wstrb_o}, 32'h0);
    if_req_i = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'h11;
    tick();
    chk1("t2_if_rvalid", if_rvalid_o, 1'b1);
    chk32("t2_if_rdata", if_rdata_o, 32'h11);
    chk1("t2_ls_rvalid_pulse", ls_rvalid_o, 1'b0);
    mem_ack_i = 1'b0;
    tick();

    // 3. Starvation guard: LS x4, IF x1, repeated (loads, so strobes forced to 0)
    if_req_i = 1'b1; if_addr_i = 32'h200;
    ls_req_i = 1'b1; ls_we_i = 1'b0; ls_addr_i = 32'h3000; ls_wstrb_i = 4'hF;
    for (int r = 0; r < 10; r++) begin
      tick();
      if (r % 5 == 4) begin
        chk1($sformatf("t3_r%0d_if_gnt", r), if_gnt_o, 1'b1);
        chk1($sformatf("t3_r%0d_ls_gnt", r), ls_gnt_o, 1'b0);
        chk32($sformatf("t3_r%0d_addr", r), mem_addr_o, 32'h200);
      end else begin
        chk1($sformatf("t3_r%0d_if_gnt", r), if_gnt_o, 1'b0);
        chk1($sformatf("t3_r%0d_ls_gnt", r), ls_gnt_o, 1'b1);
        chk32($sformatf("t3_r%0d_wstrb", r), {28'h0, mem_wstrb_o}, 32'h0);
      end
      mem_ack_i = 1'b1;
      tick();
      mem_ack_i = 1'b0;
    end
    if_req_i = 1'b0; ls_req_i = 1'b0;
    tick();
    chk1("t3_idle", busy_o, 1'b0);

    // 4. Async reset during BUSY_LS
    ls_req_i = 1'b1; ls_we_i = 1'b1; ls_addr_i = 32'h4000; ls_wdata_i = 32'h12345678;
    tick();
    chk1("t4_ls_gnt", ls_gnt_o, 1'b1);
    ls_req_i = 1'b0;
    #2 rst_i = 1'b1;
    #1;
    chk_all_zero("t4_async");
    tick();
    rst_i = 1'b0;
    mem_ack_i = 1'b1; mem_rdata_i = 32'h99;
    tick();
    chk1("t4_no_ls_rvalid", ls_rvalid_o, 1'b0);
    chk1("t4_no_if_rvalid", if_rvalid_o, 1'b0);
    chk1("t4_busy", busy_o, 1'b0);
    mem_ack_i = 1'b0;
    tick();

    // 5. Stray ack in IDLE
    mem_ack_i = 1'b1; mem_rdata_i = 32'h77;
    tick();
    chk1("t5_ls_rvalid", ls_rvalid_o, 1'b0);
    chk1("t5_if_rvalid", if_rvalid_o, 1'b0);
    chk1("t5_busy", busy_o, 1'b0);
    chk32("t5_ls_rdata", ls_rdata_o, 32'h0);
    mem_ack_i = 1'b0;
    tick();
    chk1("t5_busy_after", busy_o, 1'b0);

    // 6. Load acked in the same cycle mem_req rises
    ls_req_i = 1'b1; ls_we_i = 1'b0; ls_addr_i = 32'h3004; ls_wstrb_i = 4'hF;
    tick();
    chk1("t6_ls_gnt", ls_gnt_o, 1'b1);
    chk1("t6_busy", busy_o, 1'b1);
    chk1("t6_mem_we", mem_we_o, 1'b0);
    chk32("t6_mem_wstrb", {28'h0, mem_wstrb_o}, 32'h0);
    chk32("t6_mem_addr", mem_addr_o, 32'h3004);
    ls_req_i = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'hCAFEF00D;
    tick();
    chk1("t6_ls_rvalid", ls_rvalid_o, 1'b1);
    chk32("t6_ls_rdata", ls_rdata_o, 32'hCAFEF00D);
    chk1("t6_busy_1cyc", busy_o, 1'b0);
    chk1("t6_mem_req", mem_req_o, 1'b0);
    mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    tick();
    chk1("t6_rvalid_pulse", ls_rvalid_o, 1'b0);
    chk32("t6_rdata_hold", ls_rdata_o, 32'hCAFEF00D);
    chk1("t6_busy_stay", busy_o, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
